// File: rtl/biriscv_trace_enc_pkg.sv
// Shared definitions for the retire trace encoder: record layout, counter
// widths and the saturating drop-count helper.
package biriscv_trace_enc_pkg;

  localparam int TRACE_PC_W  = 32;
  localparam int TRACE_OP_W  = 32;
  localparam int TRACE_SEQ_W = 8;
  // pc + opcode + seq
  localparam int TRACE_REC_W = 72;
  localparam int DROP_CNT_W  = 16;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]  pc;
    logic [TRACE_OP_W-1:0]  opcode;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_rec_t;

  // Add 0..2 dropped records to the drop counter, pinning at all-ones.
  function automatic logic [DROP_CNT_W-1:0] drop_cnt_sat_add(
    input logic [DROP_CNT_W-1:0] cnt,
    input logic [1:0]            add
  );
    logic [DROP_CNT_W:0] sum_s;
    sum_s = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, add};
    if (sum_s[DROP_CNT_W]) begin
      return {DROP_CNT_W{1'b1}};
    end else begin
      return sum_s[DROP_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/biriscv_trace_fifo2w.sv
// Trace record FIFO: up to two writes per cycle (port 0 always the older
// record), one first-word-fall-through read. Head reads as zero when empty.
// The writer must never push more than the free space seen at cycle start.
module biriscv_trace_fifo2w
  import biriscv_trace_enc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr0_en,
  input  trace_rec_t             wr0_data,
  input  logic                   wr1_en,
  input  trace_rec_t             wr1_data,
  input  logic                   pop,
  output logic                   head_valid,
  output trace_rec_t             head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  trace_rec_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [AW-1:0] wr1_idx_s;
  logic [1:0]    wr_cnt_s;
  logic          pop_s;

  // Write-slot selection, write count and qualified pop.
  always_comb begin
    wr_cnt_s = {1'b0, wr0_en} + {1'b0, wr1_en};
    if (wr0_en) begin
      wr1_idx_s = wr_ptr_r + AW'(1);
    end else begin
      wr1_idx_s = wr_ptr_r;
    end
    pop_s = pop & (level_r != LW'(0));
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(wr_cnt_s);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      level_r  <= level_r + LW'(wr_cnt_s) - LW'(pop_s);
    end
  end

  // Storage array; contents are don't-care while masked by an empty level.
  always_ff @(posedge clk_i) begin
    if (wr0_en) begin
      mem_r[wr_ptr_r] <= wr0_data;
    end
    if (wr1_en) begin
      mem_r[wr1_idx_s] <= wr1_data;
    end
  end

  // Fall-through head, forced to zero when nothing is buffered.
  always_comb begin
    if (level_r != LW'(0)) begin
      head_valid = 1'b1;
      head       = mem_r[rd_ptr_r];
    end else begin
      head_valid = 1'b0;
      head       = '0;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/biriscv_trace_enc.sv
// Retire trace encoder: admits up to two retiring instructions per cycle into
// the trace FIFO, numbers every request (kept or dropped) so the sink can see
// gaps, and tracks drops with a sticky flag and a saturating counter.
module biriscv_trace_enc
  import biriscv_trace_enc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic                   retire0_valid_i,
  input  logic [31:0]            retire0_pc_i,
  input  logic [31:0]            retire0_opcode_i,
  input  logic                   retire1_valid_i,
  input  logic [31:0]            retire1_pc_i,
  input  logic [31:0]            retire1_opcode_i,
  output logic                   trace_valid_o,
  output logic [31:0]            trace_pc_o,
  output logic [31:0]            trace_opcode_o,
  output logic [7:0]             trace_seq_o,
  input  logic                   trace_accept_i,
  output logic                   overflow_o,
  output logic [15:0]            drop_count_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                   req0_s;
  logic                   req1_s;
  logic [1:0]             n_req_s;
  logic [LW-1:0]          level_s;
  logic [LW-1:0]          free_s;
  logic                   wr0_en_s;
  logic                   wr1_en_s;
  logic [1:0]             n_drop_s;
  trace_rec_t             rec0_s;
  trace_rec_t             rec1_s;
  trace_rec_t             head_s;
  logic                   head_valid_s;
  logic [TRACE_SEQ_W-1:0] seq_r;
  logic [DROP_CNT_W-1:0]  drop_cnt_r;
  logic                   overflow_r;

  // Requests this cycle and free space as seen at cycle start (no pop credit).
  always_comb begin
    req0_s  = enable_i & retire0_valid_i;
    req1_s  = enable_i & retire1_valid_i;
    n_req_s = {1'b0, req0_s} + {1'b0, req1_s};
    free_s  = LW'(DEPTH) - level_s;
  end

  // Pack requests in program order; a lone slot1 request takes the first port.
  always_comb begin
    rec0_s = '0;
    rec1_s = '0;
    if (req0_s) begin
      rec0_s.pc     = retire0_pc_i;
      rec0_s.opcode = retire0_opcode_i;
    end else begin
      rec0_s.pc     = retire1_pc_i;
      rec0_s.opcode = retire1_opcode_i;
    end
    rec0_s.seq    = seq_r;
    rec1_s.pc     = retire1_pc_i;
    rec1_s.opcode = retire1_opcode_i;
    rec1_s.seq    = seq_r + 8'd1;
  end

  // Admission: keep the oldest requests that fit, drop the rest.
  always_comb begin
    wr0_en_s = 1'b0;
    wr1_en_s = 1'b0;
    n_drop_s = 2'd0;
    case (n_req_s)
      2'd1: begin
        if (free_s != LW'(0)) begin
          wr0_en_s = 1'b1;
        end else begin
          n_drop_s = 2'd1;
        end
      end
      2'd2: begin
        if (free_s >= LW'(2)) begin
          wr0_en_s = 1'b1;
          wr1_en_s = 1'b1;
        end else if (free_s == LW'(1)) begin
          wr0_en_s = 1'b1;
          n_drop_s = 2'd1;
        end else begin
          n_drop_s = 2'd2;
        end
      end
      default: begin
        wr0_en_s = 1'b0;
        wr1_en_s = 1'b0;
        n_drop_s = 2'd0;
      end
    endcase
  end

  // Sequence counter advances once per request, written or dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_r <= 8'd0;
    end else begin
      seq_r <= seq_r + {6'd0, n_req_s};
    end
  end

  // Drop accounting; a drop in the clearing cycle survives the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_r <= 16'd0;
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      drop_cnt_r <= DROP_CNT_W'(n_drop_s);
      overflow_r <= (n_drop_s != 2'd0);
    end else begin
      drop_cnt_r <= drop_cnt_sat_add(drop_cnt_r, n_drop_s);
      overflow_r <= overflow_r | (n_drop_s != 2'd0);
    end
  end

  biriscv_trace_fifo2w #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr0_en    (wr0_en_s),
    .wr0_data  (rec0_s),
    .wr1_en    (wr1_en_s),
    .wr1_data  (rec1_s),
    .pop       (trace_accept_i),
    .head_valid(head_valid_s),
    .head      (head_s),
    .level     (level_s)
  );

  assign trace_valid_o  = head_valid_s;
  assign trace_pc_o     = head_s.pc;
  assign trace_opcode_o = head_s.opcode;
  assign trace_seq_o    = head_s.seq;
  assign overflow_o     = overflow_r;
  assign drop_count_o   = drop_cnt_r;
  assign level_o        = level_s;

endmodule

// File: tb/tb_biriscv_trace_enc.sv
// Scoreboard bench for biriscv_trace_enc: a queue-based model predicts the
// records the sink should receive; a monitor pops and compares on handshakes.
module tb_biriscv_trace_enc;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        clear_i;
  logic        retire0_valid_i;
  logic [31:0] retire0_pc_i;
  logic [31:0] retire0_opcode_i;
  logic        retire1_valid_i;
  logic [31:0] retire1_pc_i;
  logic [31:0] retire1_opcode_i;
  logic        trace_valid_o;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_opcode_o;
  logic [7:0]  trace_seq_o;
  logic        trace_accept_i;
  logic        overflow_o;
  logic [15:0] drop_count_o;
  logic [3:0]  level_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op;
    logic [7:0]  seq;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] m_seq;
  int         m_drop;
  bit         m_ovf;
  int         total = 0;
  int         bad = 0;

  always #5 clk_i = ~clk_i;

  biriscv_trace_enc #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .retire0_valid_i (retire0_valid_i),
    .retire0_pc_i    (retire0_pc_i),
    .retire0_opcode_i(retire0_opcode_i),
    .retire1_valid_i (retire1_valid_i),
    .retire1_pc_i    (retire1_pc_i),
    .retire1_opcode_i(retire1_opcode_i),
    .trace_valid_o   (trace_valid_o),
    .trace_pc_o      (trace_pc_o),
    .trace_opcode_o  (trace_opcode_o),
    .trace_seq_o     (trace_seq_o),
    .trace_accept_i  (trace_accept_i),
    .overflow_o      (overflow_o),
    .drop_count_o    (drop_count_o),
    .level_o         (level_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check state at cycle start, drive inputs, advance the model.
  task automatic step(input bit r, input bit en, input bit clr, input bit v0, input bit v1,
                      input bit acc, input logic [31:0] p0, input logic [31:0] o0,
                      input logic [31:0] p1, input logic [31:0] o1);
    int   free;
    int   drops;
    rec_t rr;
    @(negedge clk_i);
    chk("level", 32'(level_o), 32'(exp_q.size()));
    chk("valid", 32'(trace_valid_o), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("drop_count", 32'(drop_count_o), 32'(m_drop));
    if (exp_q.size() == 0) begin
      chk("empty_pc", trace_pc_o, 32'd0);
      chk("empty_opcode", trace_opcode_o, 32'd0);
      chk("empty_seq", 32'(trace_seq_o), 32'd0);
    end
    rst_i = r; enable_i = en; clear_i = clr; trace_accept_i = acc;
    retire0_valid_i = v0; retire0_pc_i = p0; retire0_opcode_i = o0;
    retire1_valid_i = v1; retire1_pc_i = p1; retire1_opcode_i = o1;
    if (r) begin
      exp_q.delete();
      m_seq  = 8'd0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      free  = DEPTH - exp_q.size();
      drops = 0;
      if (en && v0) begin
        if (free > 0) begin
          rr.pc = p0; rr.op = o0; rr.seq = m_seq;
          exp_q.push_back(rr);
          free--;
        end else begin
          drops++;
        end
        m_seq++;
      end
      if (en && v1) begin
        if (free > 0) begin
          rr.pc = p1; rr.op = o1; rr.seq = m_seq;
          exp_q.push_back(rr);
          free--;
        end else begin
          drops++;
        end
        m_seq++;
      end
      if (clr) begin
        m_drop = drops;
        m_ovf  = (drops > 0);
      end else begin
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        if (drops > 0) m_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input bit acc);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic dual(input bit acc, input logic [31:0] pc);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, acc, pc, pc ^ 32'h5a5a0000, pc + 32'd4, pc ^ 32'ha5a50000);
  endtask

  task automatic single(input bit acc, input logic [31:0] pc);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, acc, pc, pc ^ 32'h00000013, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hdead0000, 32'hdead0001, 32'hdead0004, 32'hdead0005);
  endtask

  // Monitor: on every handshake compare the head against the oldest expected record.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && trace_valid_o && trace_accept_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_record: got seq %0d expected no record", trace_seq_o);
        end else begin
          e = exp_q.pop_front();
          chk("rec_pc", trace_pc_o, e.pc);
          chk("rec_opcode", trace_opcode_o, e.op);
          chk("rec_seq", 32'(trace_seq_o), 32'(e.seq));
        end
      end
    end
  end

  // Overall time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; trace_accept_i = 1'b0;
    retire0_valid_i = 1'b0; retire0_pc_i = 32'd0; retire0_opcode_i = 32'd0;
    retire1_valid_i = 1'b0; retire1_pc_i = 32'd0; retire1_opcode_i = 32'd0;
    m_seq = 8'd0; m_drop = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk_i);

    // Single retire into an empty FIFO, visible the next cycle with seq 0.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h00000013, 32'd0, 32'd0);
    idle(1'b0);
    chk("first_valid", 32'(trace_valid_o), 32'd1);
    chk("first_pc", trace_pc_o, 32'h80000000);
    chk("first_opcode", trace_opcode_o, 32'h00000013);
    chk("first_seq", 32'(trace_seq_o), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Dual retire with the sink always accepting.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h13, 32'h104, 32'h93);
    repeat (3) idle(1'b1);
    chk("dual_drained", 32'(level_o), 32'd0);

    // Fill, overflow by two, drain, then check the sequence gap.
    do_reset();
    for (int i = 0; i < 4; i++) dual(1'b0, 32'h2000 + 32'(i * 8));
    dual(1'b0, 32'h3000);
    idle(1'b0);
    chk("full_level", 32'(level_o), 32'd8);
    chk("full_drops", 32'(drop_count_o), 32'd2);
    chk("full_ovf", 32'(overflow_o), 32'd1);
    repeat (8) idle(1'b1);
    single(1'b0, 32'h4000);
    idle(1'b0);
    chk("gap_seq", 32'(trace_seq_o), 32'd10);
    repeat (2) idle(1'b1);

    // Clear with no concurrent drop.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    idle(1'b0);
    chk("clear_ovf", 32'(overflow_o), 32'd0);
    chk("clear_drops", 32'(drop_count_o), 32'd0);

    // One slot free plus a pop: slot0 kept, slot1 dropped, level unchanged.
    do_reset();
    for (int i = 0; i < 7; i++) single(1'b0, 32'h5000 + 32'(i * 4));
    dual(1'b1, 32'h6000);
    idle(1'b0);
    chk("edge_level", 32'(level_o), 32'd7);
    chk("edge_drops", 32'(drop_count_o), 32'd1);
    repeat (8) idle(1'b1);

    // Clear and drop in the same cycle: the drop wins.
    for (int i = 0; i < 4; i++) dual(1'b0, 32'h6100 + 32'(i * 8));
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h6200, 32'h1, 32'h6204, 32'h2);
    idle(1'b0);
    chk("clr_drop_ovf", 32'(overflow_o), 32'd1);
    chk("clr_drop_cnt", 32'(drop_count_o), 32'd2);
    repeat (8) idle(1'b1);

    // Reset mid-stream with five records buffered.
    do_reset();
    for (int i = 0; i < 5; i++) single(1'b0, 32'h7000 + 32'(i * 4));
    do_reset();
    idle(1'b0);
    chk("rst_valid", 32'(trace_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    single(1'b0, 32'h7100);
    idle(1'b0);
    chk("rst_seq", 32'(trace_seq_o), 32'd0);
    idle(1'b1);

    // Drive the drop counter into saturation.
    do_reset();
    for (int i = 0; i < 4; i++) dual(1'b0, 32'h8000 + 32'(i * 8));
    for (int i = 0; i < 32766; i++) dual(1'b0, 32'h9000);
    idle(1'b0);
    chk("near_sat", 32'(drop_count_o), 32'd65532);
    single(1'b0, 32'h9100);
    single(1'b0, 32'h9104);
    single(1'b0, 32'h9108);
    idle(1'b0);
    chk("sat", 32'(drop_count_o), 32'h0000ffff);
    repeat (8) idle(1'b1);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 6), $urandom, $urandom, $urandom, $urandom);
    end
    repeat (DEPTH + 2) idle(1'b1);
    idle(1'b0);
    chk("final_empty", 32'(level_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
